// File: rtl/ysyx_24100005_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU (read-only) and the LSU.
// One transaction in flight; the grant is held from request through the response handshake.
module ysyx_24100005_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_rsp_valid,
   input  logic                ifu_rsp_ready,
   output logic [DATA_W-1:0]   ifu_rsp_rdata,
   output logic                ifu_rsp_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic                lsu_req_wen,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [DATA_W/8-1:0] lsu_req_wmask,
   output logic                lsu_rsp_valid,
   input  logic                lsu_rsp_ready,
   output logic [DATA_W-1:0]   lsu_rsp_rdata,
   output logic                lsu_rsp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_rsp_valid,
   output logic                mem_rsp_ready,
   input  logic [DATA_W-1:0]   mem_rsp_rdata,
   input  logic                mem_rsp_err
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_IFU_REQ = 3'd1,
      S_IFU_RSP = 3'd2,
      S_LSU_REQ = 3'd3,
      S_LSU_RSP = 3'd4
   } state_e;

   localparam logic GRANT_IFU = 1'b0;
   localparam logic GRANT_LSU = 1'b1;

   state_e state_q, state_d;
   logic   last_grant_q, last_grant_d;

   // State and round-robin pointer registers; LSU as last grant lets IFU win the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= GRANT_LSU;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state and output decode; outputs depend only on the registered grant,
   // so a master's req_valid never reaches mem_req_valid in the same cycle.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      ifu_rsp_rdata = '0;
      ifu_rsp_err   = 1'b0;
      lsu_req_ready = 1'b0;
      lsu_rsp_valid = 1'b0;
      lsu_rsp_rdata = '0;
      lsu_rsp_err   = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      mem_req_wen   = 1'b0;
      mem_req_wdata = '0;
      mem_req_wmask = '0;
      mem_rsp_ready = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ifu_req_valid && (!lsu_req_valid || (last_grant_q == GRANT_LSU))) begin
               state_d      = S_IFU_REQ;
               last_grant_d = GRANT_IFU;
            end else if (lsu_req_valid) begin
               state_d      = S_LSU_REQ;
               last_grant_d = GRANT_LSU;
            end else begin
               state_d      = S_IDLE;
            end
         end
         S_IFU_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = ifu_req_addr;
            ifu_req_ready = mem_req_ready;
            if (mem_req_ready) begin
               state_d = S_IFU_RSP;
            end else begin
               state_d = S_IFU_REQ;
            end
         end
         S_IFU_RSP: begin
            ifu_rsp_valid = mem_rsp_valid;
            ifu_rsp_rdata = mem_rsp_rdata;
            ifu_rsp_err   = mem_rsp_err;
            mem_rsp_ready = ifu_rsp_ready;
            if (mem_rsp_valid && ifu_rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_IFU_RSP;
            end
         end
         S_LSU_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = lsu_req_addr;
            mem_req_wen   = lsu_req_wen;
            mem_req_wdata = lsu_req_wdata;
            mem_req_wmask = lsu_req_wmask;
            lsu_req_ready = mem_req_ready;
            if (mem_req_ready) begin
               state_d = S_LSU_RSP;
            end else begin
               state_d = S_LSU_REQ;
            end
         end
         S_LSU_RSP: begin
            lsu_rsp_valid = mem_rsp_valid;
            lsu_rsp_rdata = mem_rsp_rdata;
            lsu_rsp_err   = mem_rsp_err;
            mem_rsp_ready = lsu_rsp_ready;
            if (mem_rsp_valid && lsu_rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_LSU_RSP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Bench for ysyx_24100005_mem_arbiter: directed cycle table followed by randomized
// master/slave traffic checked against a transaction-ownership reference model.
module tb_ysyx_24100005_mem_arbiter;

   typedef struct packed {
      logic        rst;
      logic        ifu_v;
      logic [31:0] ifu_a;
      logic        ifu_rr;
      logic        lsu_v;
      logic [31:0] lsu_a;
      logic        lsu_w;
      logic [31:0] lsu_wd;
      logic [3:0]  lsu_wm;
      logic        lsu_rr;
      logic        mqr;
      logic        msv;
      logic [31:0] msd;
      logic        mse;
   } in_t;

   // First nine fields form the control vector used in the table:
   // {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, lsu_req_ready, lsu_rsp_valid,
   //  lsu_rsp_err, mem_req_valid, mem_req_wen, mem_rsp_ready}
   typedef struct packed {
      logic        ifu_req_ready;
      logic        ifu_rsp_valid;
      logic        ifu_rsp_err;
      logic        lsu_req_ready;
      logic        lsu_rsp_valid;
      logic        lsu_rsp_err;
      logic        mem_req_valid;
      logic        mem_req_wen;
      logic        mem_rsp_ready;
      logic [31:0] ifu_rsp_rdata;
      logic [31:0] lsu_rsp_rdata;
      logic [31:0] mem_req_addr;
      logic [31:0] mem_req_wdata;
      logic [3:0]  mem_req_wmask;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   localparam logic [31:0] A = 32'h8000_0000;
   localparam logic [31:0] L = 32'h8000_1000;
   localparam logic [31:0] Z = 32'h0000_0000;
   localparam int NTBL = 38;
   localparam int OWN_NONE = 0;
   localparam int OWN_IFU  = 1;
   localparam int OWN_LSU  = 2;

   logic        clk;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
   logic [31:0] ifu_req_addr, ifu_rsp_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
   logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
   logic [3:0]  lsu_req_wmask;
   logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
   logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
   logic [3:0]  mem_req_wmask;

   out_t dut_o;
   int   n_vec;
   int   n_err;

   // Reference model: who owns the port, whether its request was accepted, and who was served last
   int   m_owner;
   logic m_rsp;
   int   m_last;

   vec_t tbl [NTBL];
   in_t  r;
   out_t e;
   logic ih, lh, lw_h;
   logic [31:0] ia_h, la_h, lwd_h;
   logic [3:0]  lwm_h;

   ysyx_24100005_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
      .ifu_rsp_err(ifu_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
      .lsu_rsp_err(lsu_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
      .mem_rsp_err(mem_rsp_err)
   );

   assign dut_o = {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, lsu_req_ready, lsu_rsp_valid,
                   lsu_rsp_err, mem_req_valid, mem_req_wen, mem_rsp_ready,
                   ifu_rsp_rdata, lsu_rsp_rdata, mem_req_addr, mem_req_wdata, mem_req_wmask};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t row(
      input logic rst_i, input logic iv, input logic [31:0] ia, input logic irr,
      input logic lv, input logic [31:0] la, input logic lw, input logic [31:0] lwd,
      input logic [3:0] lwm, input logic lrr, input logic mqr, input logic msv,
      input logic [31:0] msd, input logic mse, input logic [8:0] ectrl,
      input logic [31:0] eird, input logic [31:0] elrd, input logic [31:0] eaddr,
      input logic [31:0] ewd, input logic [3:0] ewm);
      vec_t v;
      v.i = {rst_i, iv, ia, irr, lv, la, lw, lwd, lwm, lrr, mqr, msv, msd, mse};
      v.o = {ectrl, eird, elrd, eaddr, ewd, ewm};
      return v;
   endfunction

   task automatic apply(input in_t i);
      rst           = i.rst;
      ifu_req_valid = i.ifu_v;
      ifu_req_addr  = i.ifu_a;
      ifu_rsp_ready = i.ifu_rr;
      lsu_req_valid = i.lsu_v;
      lsu_req_addr  = i.lsu_a;
      lsu_req_wen   = i.lsu_w;
      lsu_req_wdata = i.lsu_wd;
      lsu_req_wmask = i.lsu_wm;
      lsu_rsp_ready = i.lsu_rr;
      mem_req_ready = i.mqr;
      mem_rsp_valid = i.msv;
      mem_rsp_rdata = i.msd;
      mem_rsp_err   = i.mse;
   endtask

   task automatic check(input string name, input out_t act, input out_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Owner sees the slave: the request side until accepted, then the response side.
   function automatic out_t model_out(input in_t i);
      out_t o;
      o = '0;
      if (m_owner == OWN_IFU && !m_rsp) begin
         o.mem_req_valid = 1'b1;
         o.mem_req_addr  = i.ifu_a;
         o.ifu_req_ready = i.mqr;
      end else if (m_owner == OWN_IFU) begin
         o.ifu_rsp_valid = i.msv;
         o.ifu_rsp_rdata = i.msd;
         o.ifu_rsp_err   = i.mse;
         o.mem_rsp_ready = i.ifu_rr;
      end else if (m_owner == OWN_LSU && !m_rsp) begin
         o.mem_req_valid = 1'b1;
         o.mem_req_addr  = i.lsu_a;
         o.mem_req_wen   = i.lsu_w;
         o.mem_req_wdata = i.lsu_wd;
         o.mem_req_wmask = i.lsu_wm;
         o.lsu_req_ready = i.mqr;
      end else if (m_owner == OWN_LSU) begin
         o.lsu_rsp_valid = i.msv;
         o.lsu_rsp_rdata = i.msd;
         o.lsu_rsp_err   = i.mse;
         o.mem_rsp_ready = i.lsu_rr;
      end
      return o;
   endfunction

   task automatic model_step(input in_t i);
      if (i.rst) begin
         m_owner = OWN_NONE;
         m_rsp   = 1'b0;
         m_last  = OWN_LSU;
      end else if (m_owner == OWN_NONE) begin
         if (i.ifu_v && i.lsu_v) m_owner = (m_last == OWN_IFU) ? OWN_LSU : OWN_IFU;
         else if (i.ifu_v)       m_owner = OWN_IFU;
         else if (i.lsu_v)       m_owner = OWN_LSU;
         if (m_owner != OWN_NONE) m_last = m_owner;
      end else if (!m_rsp) begin
         if (i.mqr) m_rsp = 1'b1;
      end else if (i.msv && ((m_owner == OWN_IFU) ? i.ifu_rr : i.lsu_rr)) begin
         m_owner = OWN_NONE;
         m_rsp   = 1'b0;
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_owner = OWN_NONE;
      m_rsp   = 1'b0;
      m_last  = OWN_LSU;
      ih = 1'b0; lh = 1'b0; lw_h = 1'b0;
      ia_h = Z; la_h = Z; lwd_h = Z; lwm_h = 4'h0;

      //            rst  iv ia irr lv la lw lwd           lwm   lrr mqr msv msd            mse  ctrl          ird            lrd            addr wd            wm
      // reset with both requesting, then contention alternates IFU, LSU, IFU, LSU
      tbl[0]  = row(1'b1,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[1]  = row(1'b1,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[2]  = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[3]  = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b1,1'b0,Z,1'b0,9'b100_000_100,Z,Z,A,Z,4'h0);
      tbl[4]  = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b1,32'h0000_0413,1'b0,9'b010_000_001,32'h0000_0413,Z,Z,Z,4'h0);
      tbl[5]  = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[6]  = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b1,1'b0,Z,1'b0,9'b000_100_100,Z,Z,L,Z,4'h0);
      tbl[7]  = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b1,32'h1234_5678,1'b1,9'b000_011_001,Z,32'h1234_5678,Z,Z,4'h0);
      tbl[8]  = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[9]  = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_100,Z,Z,A,Z,4'h0);
      tbl[10] = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b1,1'b0,Z,1'b0,9'b100_000_100,Z,Z,A,Z,4'h0);
      tbl[11] = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b1,32'hCAFE_0001,1'b0,9'b010_000_001,32'hCAFE_0001,Z,Z,Z,4'h0);
      tbl[12] = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[13] = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b1,1'b0,Z,1'b0,9'b000_100_100,Z,Z,L,Z,4'h0);
      tbl[14] = row(1'b0,1'b0,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b1,32'h0BAD_F00D,1'b0,9'b000_010_001,Z,32'h0BAD_F00D,Z,Z,4'h0);
      tbl[15] = row(1'b0,1'b0,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      // lone IFU fetch: LSU side stays silent, write enable forced low
      tbl[16] = row(1'b0,1'b1,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[17] = row(1'b0,1'b1,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b1,1'b0,Z,1'b0,9'b100_000_100,Z,Z,A,Z,4'h0);
      tbl[18] = row(1'b0,1'b0,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b1,32'h0000_0413,1'b0,9'b010_000_001,32'h0000_0413,Z,Z,Z,4'h0);
      // LSU write held 4 cycles by a slow slave; stray response in REQ ignored; response backpressure
      tbl[19] = row(1'b0,1'b0,A,1'b1,1'b1,L,1'b1,32'hDEAD_BEEF,4'hF,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[20] = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b1,32'hDEAD_BEEF,4'hF,1'b1,1'b0,1'b1,32'hFFFF_FFFF,1'b1,9'b000_000_110,Z,Z,L,32'hDEAD_BEEF,4'hF);
      tbl[21] = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b1,32'hDEAD_BEEF,4'hF,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_110,Z,Z,L,32'hDEAD_BEEF,4'hF);
      tbl[22] = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b1,32'hDEAD_BEEF,4'hF,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_110,Z,Z,L,32'hDEAD_BEEF,4'hF);
      tbl[23] = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b1,32'hDEAD_BEEF,4'hF,1'b1,1'b1,1'b0,Z,1'b0,9'b000_100_110,Z,Z,L,32'hDEAD_BEEF,4'hF);
      tbl[24] = row(1'b0,1'b1,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b0,1'b0,1'b1,32'h5555_AAAA,1'b0,9'b000_010_000,Z,32'h5555_AAAA,Z,Z,4'h0);
      tbl[25] = row(1'b0,1'b1,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b0,1'b0,1'b1,32'h5555_AAAA,1'b0,9'b000_010_000,Z,32'h5555_AAAA,Z,Z,4'h0);
      tbl[26] = row(1'b0,1'b1,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b1,32'h5555_AAAA,1'b0,9'b000_010_001,Z,32'h5555_AAAA,Z,Z,4'h0);
      tbl[27] = row(1'b0,1'b1,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[28] = row(1'b0,1'b1,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b1,1'b0,Z,1'b0,9'b100_000_100,Z,Z,A,Z,4'h0);
      tbl[29] = row(1'b0,1'b0,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,32'h1111_2222,1'b0,9'b000_000_001,32'h1111_2222,Z,Z,Z,4'h0);
      tbl[30] = row(1'b0,1'b0,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b1,32'h0000_0013,1'b0,9'b010_000_001,32'h0000_0013,Z,Z,Z,4'h0);
      // reset while LSU waits for its response with IFU pending
      tbl[31] = row(1'b0,1'b0,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[32] = row(1'b0,1'b1,A,1'b1,1'b1,L,1'b0,Z,4'h0,1'b1,1'b1,1'b0,Z,1'b0,9'b000_100_100,Z,Z,L,Z,4'h0);
      tbl[33] = row(1'b1,1'b1,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_001,Z,Z,Z,Z,4'h0);
      tbl[34] = row(1'b0,1'b1,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);
      tbl[35] = row(1'b0,1'b1,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b1,1'b0,Z,1'b0,9'b100_000_100,Z,Z,A,Z,4'h0);
      tbl[36] = row(1'b0,1'b0,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b1,32'h0000_0297,1'b0,9'b010_000_001,32'h0000_0297,Z,Z,Z,4'h0);
      tbl[37] = row(1'b0,1'b0,A,1'b1,1'b0,L,1'b0,Z,4'h0,1'b1,1'b0,1'b0,Z,1'b0,9'b000_000_000,Z,Z,Z,Z,4'h0);

      apply(tbl[0].i);
      @(posedge clk);
      #1;
      for (int k = 0; k < NTBL; k++) begin
         apply(tbl[k].i);
         @(negedge clk);
         check($sformatf("table[%0d]", k), dut_o, tbl[k].o);
         @(posedge clk);
         #1;
      end

      // Random traffic: masters hold requests until accepted, slave answers at random
      for (int c = 0; c < 3000; c++) begin
         r = '0;
         r.rst = (c == 0) || ($urandom_range(63) == 0);
         if (!ih && ($urandom_range(2) == 0)) begin
            ih   = 1'b1;
            ia_h = $urandom & 32'hFFFF_FFFC;
         end
         if (!lh && ($urandom_range(2) == 0)) begin
            lh    = 1'b1;
            la_h  = $urandom;
            lw_h  = 1'($urandom_range(1));
            lwd_h = $urandom;
            lwm_h = 4'($urandom_range(15));
         end
         r.ifu_v  = ih;
         r.ifu_a  = ia_h;
         r.ifu_rr = ($urandom_range(3) != 0);
         r.lsu_v  = lh;
         r.lsu_a  = la_h;
         r.lsu_w  = lw_h;
         r.lsu_wd = lwd_h;
         r.lsu_wm = lwm_h;
         r.lsu_rr = ($urandom_range(3) != 0);
         r.mqr    = 1'($urandom_range(1));
         r.msv    = 1'($urandom_range(1));
         r.msd    = $urandom;
         r.mse    = ($urandom_range(7) == 0);
         apply(r);
         @(negedge clk);
         e = model_out(r);
         check($sformatf("random[%0d]", c), dut_o, e);
         if (e.ifu_req_ready) ih = 1'b0;
         if (e.lsu_req_ready) lh = 1'b0;
         if (r.rst) begin
            ih = 1'b0;
            lh = 1'b0;
         end
         model_step(r);
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
